// File: rtl/regfile_writeback_arbiter.sv
// Register file write-port arbiter: pipeline writeback, mul/div FIFO,
// and the pending-destination scoreboard used by the hazard unit.
module regfile_writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic        md_valid,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic [4:0]  rf_w_address,
    output logic [31:0] rf_w_data,
    output logic        rf_w_enable,
    output logic [31:0] pending,
    output logic [1:0]  q_count
);

    localparam logic [1:0] LAST    = 2'(DEPTH - 1);
    localparam logic [1:0] DEPTH_C = 2'(DEPTH);

    logic [4:0]  q_rd   [4];
    logic [31:0] q_data [4];
    logic [1:0]  head;
    logic [1:0]  tail;

    logic        xfer;
    logic        fifo_nempty;
    logic        sel_pipe;
    logic        sel_fifo;
    logic        sel_byp;
    logic        sel_any;
    logic        sel_md;
    logic        enq;
    logic        deq;
    logic [4:0]  sel_rd;
    logic [31:0] sel_data;
    logic [31:0] pend_next;
    logic [1:0]  count_next;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign md_ready = (q_count < DEPTH_C);

    always_comb begin
        xfer        = md_valid && md_ready;
        fifo_nempty = (q_count != 2'd0);
        sel_pipe    = pipe_valid;
        sel_fifo    = !pipe_valid && fifo_nempty;
        sel_byp     = !pipe_valid && !fifo_nempty && md_valid;
        sel_any     = sel_pipe || sel_fifo || sel_byp;
        sel_md      = sel_fifo || sel_byp;
        // A bypassed result is written directly, never stored.
        enq         = xfer && !sel_byp;
        deq         = sel_fifo;
    end

    always_comb begin
        sel_rd   = 5'd0;
        sel_data = 32'd0;
        unique case (1'b1)
            sel_pipe: begin
                sel_rd   = pipe_rd;
                sel_data = pipe_data;
            end
            sel_fifo: begin
                sel_rd   = q_rd[head];
                sel_data = q_data[head];
            end
            sel_byp: begin
                sel_rd   = md_rd;
                sel_data = md_data;
            end
            default: begin
                sel_rd   = 5'd0;
                sel_data = 32'd0;
            end
        endcase
    end

    // A new issue outranks the retirement of an older op to the same rd.
    always_comb begin
        pend_next = pending;
        if (sel_md) begin
            pend_next[sel_rd] = 1'b0;
        end
        if (md_issue) begin
            pend_next[md_issue_rd] = 1'b1;
        end
        pend_next[0] = 1'b0;
    end

    always_comb begin
        count_next = q_count;
        unique case ({enq, deq})
            2'b10:   count_next = q_count + 2'd1;
            2'b01:   count_next = q_count - 2'd1;
            default: count_next = q_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_w_enable  <= 1'b0;
            rf_w_address <= 5'd0;
            rf_w_data    <= 32'd0;
            pending      <= 32'd0;
            q_count      <= 2'd0;
            head         <= 2'd0;
            tail         <= 2'd0;
        end else begin
            rf_w_enable <= sel_any && (sel_rd != 5'd0);
            if (sel_any) begin
                rf_w_address <= sel_rd;
                rf_w_data    <= sel_data;
            end
            pending <= pend_next;
            q_count <= count_next;
            if (deq) begin
                head <= ptr_inc(head);
            end
            if (enq) begin
                tail <= ptr_inc(tail);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[tail]   <= md_rd;
            q_data[tail] <= md_data;
        end
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Writer side of the 32x32 register file write port (w_address / w_data / w_enable).
- Merges two result sources onto the single write port: the in-order pipeline writeback path (ALU and load results) and the long-latency multiply/divide unit.
- Buffers mul/div results in a small FIFO with valid/ready backpressure.
- Keeps a pending-destination scoreboard that the hazard unit uses to stall readers of registers still awaiting a mul/div result.

Parameters:
DEPTH, 2, mul/div result FIFO entries; legal range 1..3.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pipe_valid  input  1  pipeline writeback result present this cycle
pipe_rd  input  5  pipeline destination register
pipe_data  input  32  pipeline result
md_issue  input  1  mul/div op issued this cycle
md_issue_rd  input  5  destination register of the issued mul/div op
md_valid  input  1  mul/div result offered
md_rd  input  5  mul/div result destination
md_data  input  32  mul/div result
md_ready  output  1  arbiter accepts the mul/div result this cycle
rf_w_address  output  5  register file write address
rf_w_data  output  32  register file write data
rf_w_enable  output  1  register file write enable
pending  output  32  bit i set = register i awaits a mul/div writeback
q_count  output  2  current FIFO occupancy

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
- Reset values:
  - rf_w_enable=0, rf_w_address=0, rf_w_data=0.
  - pending=0, q_count=0, FIFO empty.
- Write-port outputs are registered. A source selected in cycle N drives rf_* during cycle N+1, and the register file captures it at the end of N+1.
- md_ready is combinational and equals (q_count < DEPTH).
- Handshake: a mul/div result transfers when md_valid && md_ready at a rising edge. The mul/div unit holds md_rd/md_data stable while md_valid && !md_ready.
- Per-cycle selection, in priority order:
  1. pipe_valid=1: select pipeline. A mul/div transfer this cycle is enqueued.
  2. Else FIFO non-empty: select FIFO head and dequeue. A simultaneous transfer is enqueued, so the count is unchanged.
  3. Else md_valid=1: bypass. Write the mul/div result directly and do not enqueue it.
  4. Else: rf_w_enable=0 next cycle.
- Register r0: any selected write with destination 0 produces rf_w_enable=0. It is still consumed (dequeued or accepted) normally.
- FIFO:
  - Circular buffer with head/tail pointers that wrap at DEPTH.
  - Order is preserved: results are written to the register file in acceptance order.
  - Full (q_count=DEPTH) forces md_ready=0.
  - Enqueue and dequeue in the same cycle while full cannot occur, because md_ready is already 0.
- Scoreboard:
  - On md_issue with md_issue_rd != 0, set pending[md_issue_rd] at the edge.
  - When a mul/div result (FIFO or bypass) is selected, clear pending[rd] at the same edge as the selection, not when rf_w_enable asserts.
  - Set and clear of the same bit in the same cycle: set wins, because the newer issue is outstanding.
  - Pipeline writes never change pending.
  - pending[0] is always 0.
- Reset mid-operation: FIFO contents, in-flight write and scoreboard are discarded. rf_w_enable drops immediately (asynchronously).
- No combinational path from pipe_* to rf_*.

Test Plan:
- Pipeline only: pipe_valid=1, rd=5, data=0xDEADBEEF at cycle N -> rf_w_enable=1, addr=5, data=0xDEADBEEF during N+1; rf_w_enable=0 in N+2.
- Bypass with scoreboard: md_issue rd=9, then 3 cycles later md_valid rd=9, data=0x12345678 with pipe idle -> md_ready=1, write in the following cycle, pending[9] 1->0 at the selection edge.
- Collision: pipe_valid rd=3 and md_valid rd=7 in the same cycle -> rd=3 written first, rd=7 written next cycle from FIFO; q_count goes 1 then 0.
- Backpressure, DEPTH=2: pipe_valid held 4 cycles while md_valid offers 0xA, 0xB, 0xC -> md_ready=0 after two accepts; after the pipe goes idle, writes occur in order A, B, then C once accepted.
- r0 and same-cycle set/clear: md_issue rd=0 -> pending stays 0; md result rd=0 -> no rf write but the result is consumed. md_issue rd=4 in the same cycle as the rd=4 result selection -> pending[4] remains 1.
- Async reset: assert reset mid-cycle with q_count=2 -> rf_w_enable, pending and q_count go to 0 without a clock edge. After release, the first pipe write is correct.
